// File: rtl/usb_rx_pack.sv
// usb_rx_pack: packs valid-qualified PHY bytes into a two-bank ping-pong buffer and replays
// each complete packet to usb_rx as one gap-free burst, paced by the usb_rx fs/fd handshake.
// Optional macro USB_RX_PACK_STAT_EN adds the saturating drop_cnt port and counter.
module usb_rx_pack #(
  parameter int unsigned AW  = 12,
  parameter logic [15:0] TMO = 16'd4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  din,
  input  logic        din_vld,
  input  logic        din_eop,
  output logic [7:0]  usb_rxd,
  input  logic        rx_fs,
  input  logic        rx_fd,
  output logic        busy
`ifdef USB_RX_PACK_STAT_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int unsigned Depth = 1 << AW;
  localparam logic [AW:0] MaxLen = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {FIdle, FFill, FDisc} fill_st_e;
  typedef enum logic [2:0] {RIdle, RPlay, RWfs, RWfd, RGap} play_st_e;

  fill_st_e    f_st_q;
  play_st_e    p_st_q;
  logic [7:0]  mem [2*Depth];
  logic [1:0]  full_q;
  logic [AW:0] blen_q [2];
  logic [AW:0] wlen_q;
  logic        fill_bank_q;
  logic        play_bank_q;
  logic [AW:0] ptr_q;
  logic [15:0] tmo_q;

  logic        sync_ok;
  logic        ovf;
  logic        wr_en;
  logic [AW:0] wr_addr;
  logic        fill_done;
  logic        play_done;

  // Write-side decode: what the current input byte does to the buffer this cycle.
  always_comb begin
    sync_ok   = (din == 8'h0F) && !full_q[fill_bank_q] && !din_eop;
    ovf       = (wlen_q == MaxLen);
    wr_en     = 1'b0;
    fill_done = 1'b0;
    wr_addr   = {fill_bank_q, wlen_q[AW-1:0]};
    if (din_vld) begin
      unique case (f_st_q)
        FIdle: begin
          if (sync_ok) begin
            wr_en   = 1'b1;
            wr_addr = {fill_bank_q, {AW{1'b0}}};
          end
        end
        FFill: begin
          if (!ovf) begin
            wr_en     = 1'b1;
            fill_done = din_eop;
          end
        end
        default: ;
      endcase
    end
  end

  // Replay of the current bank finishes on the cycle after its last byte was read.
  assign play_done = (p_st_q == RPlay) && (ptr_q == blen_q[play_bank_q]);

  // Buffer write port; left unreset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= din;
  end

  // Fill FSM: accepts a packet only when it starts with SYNC into an empty bank.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      f_st_q      <= FIdle;
      wlen_q      <= '0;
      fill_bank_q <= 1'b0;
    end else if (din_vld) begin
      unique case (f_st_q)
        FIdle: begin
          if (sync_ok) begin
            wlen_q <= {{AW{1'b0}}, 1'b1};
            f_st_q <= FFill;
          end else if (!din_eop) begin
            f_st_q <= FDisc;
          end
        end
        FFill: begin
          if (ovf) begin
            f_st_q <= din_eop ? FIdle : FDisc;
          end else begin
            wlen_q <= wlen_q + 1'b1;
            if (din_eop) begin
              fill_bank_q <= ~fill_bank_q;
              f_st_q      <= FIdle;
            end
          end
        end
        FDisc: begin
          if (din_eop) f_st_q <= FIdle;
        end
        default: f_st_q <= FIdle;
      endcase
    end
  end

  // Bank full flags and stored lengths; set and clear never hit the same bank together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q    <= 2'b00;
      blen_q[0] <= '0;
      blen_q[1] <= '0;
    end else begin
      if (play_done) full_q[play_bank_q] <= 1'b0;
      if (fill_done) begin
        full_q[fill_bank_q] <= 1'b1;
        blen_q[fill_bank_q] <= wlen_q + 1'b1;
      end
    end
  end

  // Replay FSM: registered read straight into usb_rxd, then waits out the usb_rx handshake.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p_st_q      <= RIdle;
      ptr_q       <= '0;
      tmo_q       <= '0;
      play_bank_q <= 1'b0;
      usb_rxd     <= 8'h00;
    end else begin
      usb_rxd <= 8'h00;
      unique case (p_st_q)
        RIdle: begin
          if (full_q[play_bank_q]) begin
            ptr_q  <= '0;
            p_st_q <= RPlay;
          end
        end
        RPlay: begin
          if (play_done) begin
            play_bank_q <= ~play_bank_q;
            tmo_q       <= '0;
            p_st_q      <= RWfs;
          end else begin
            usb_rxd <= mem[{play_bank_q, ptr_q[AW-1:0]}];
            ptr_q   <= ptr_q + 1'b1;
          end
        end
        RWfs: begin
          if (rx_fs) begin
            p_st_q <= RWfd;
          end else if (tmo_q == TMO - 16'd1) begin
            p_st_q <= RGap;
          end else begin
            tmo_q <= tmo_q + 16'd1;
          end
        end
        RWfd: begin
          if (rx_fd) p_st_q <= RGap;
        end
        RGap:    p_st_q <= RIdle;
        default: p_st_q <= RIdle;
      endcase
    end
  end

  assign busy = (p_st_q != RIdle);

`ifdef USB_RX_PACK_STAT_EN
  logic drop;

  // A packet is dropped at its first byte (bad SYNC, no free bank, 1-byte) or on overflow.
  assign drop = din_vld && (((f_st_q == FIdle) && !sync_ok) || ((f_st_q == FFill) && ovf));

  // Saturating dropped-packet counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt <= 16'h0000;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_usb_rx_pack.sv
// Testbench for usb_rx_pack (AW=4, TMO=16): directed table, hand sequences, random traffic
// against a packet-scheduling model of the replay timeline.
module tb_usb_rx_pack;

  localparam int unsigned AW = 4;
  localparam logic [15:0] TMO = 16'd16;
  localparam int MaxLen = 16;
  localparam int GapHs  = 5;   // replay start to next start beyond len, fs/fd held high
  localparam int GapTmo = 19;  // same with fs never asserted (TMO + 3)

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0;
  logic       din_eop = 1'b0;
  logic       rx_fs = 1'b0;
  logic       rx_fd = 1'b0;
  logic [7:0] usb_rxd;
  logic       busy;
`ifdef USB_RX_PACK_STAT_EN
  logic [15:0] drop_cnt;
  int          exp_drops = 0;
`endif

  usb_rx_pack #(.AW(AW), .TMO(TMO)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (din),
    .din_vld (din_vld),
    .din_eop (din_eop),
    .usb_rxd (usb_rxd),
    .rx_fs   (rx_fs),
    .rx_fd   (rx_fd),
    .busy    (busy)
`ifdef USB_RX_PACK_STAT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  // ecnt = number of rising edges so far; obs[e] is the output seen after edge e.
  int         ecnt = 0;
  logic [7:0] obs   [65536];
  logic       obs_b [65536];
  logic [7:0] exp_d [65536];
  logic       exp_b [65536];

  always @(posedge clk) ecnt <= ecnt + 1;
  always @(negedge clk) begin
    if (ecnt < 65536) begin
      obs[ecnt]   = usb_rxd;
      obs_b[ecnt] = busy;
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  logic [7:0] pkt[$];
  int sync_e;
  int eop_e;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic mk_pkt(input logic [7:0] first, input int len);
    pkt.delete();
    pkt.push_back(first);
    for (int i = 1; i < len; i++) pkt.push_back(8'($urandom));
  endtask

  // Drives pkt, optionally with random valid gaps carrying garbage data.
  task automatic send_pkt(input int gap_pct);
    for (int i = 0; i < pkt.size(); i++) begin
      while (int'($urandom_range(99)) < gap_pct) begin
        din_vld = 1'b0;
        din     = 8'($urandom);
        din_eop = 1'($urandom);
        tick();
      end
      din     = pkt[i];
      din_vld = 1'b1;
      din_eop = (i == pkt.size() - 1);
      if (i == 0) sync_e = ecnt + 1;
      if (din_eop) eop_e = ecnt + 1;
      tick();
    end
    din_vld = 1'b0;
    din_eop = 1'b0;
  endtask

  task automatic do_reset(output int re);
    rst_n   = 1'b0;
    din_vld = 1'b0;
    re      = ecnt + 1;
    tick();
    rst_n = 1'b1;
`ifdef USB_RX_PACK_STAT_EN
    exp_drops = 0;
`endif
  endtask

  function automatic int nonzero(input int a, input int b);
    int n = 0;
    for (int c = a; c <= b; c++) if (obs[c] != 8'h00) n++;
    return n;
  endfunction

  // Random traffic; hs selects fs/fd held high or never asserted (timeout path).
  task automatic rand_phase(input bit hs, input int npkt);
    int re, start, g, s, e, len, k, p, r, gap_pct;
    int ap[$];
    int al[$];
    bit ok;
    logic [7:0] first;
    rx_fs = hs;
    rx_fd = hs;
    g = hs ? GapHs : GapTmo;
    do_reset(re);
    start = ecnt + 1;
    for (int c = start; c < start + 8000; c++) begin
      exp_d[c] = 8'h00;
      exp_b[c] = 1'b0;
    end
    for (int n = 0; n < npkt; n++) begin
      r = int'($urandom_range(9));
      gap_pct = (r == 9) ? 0 : int'($urandom_range(40));
      len = 2 + int'($urandom_range(MaxLen - 2));
      first = 8'h0F;
      if (r == 6) begin
        len = 1 + int'($urandom_range(5));
        do first = 8'($urandom); while (first == 8'h0F);
      end else if (r == 7) begin
        len = 1;
      end else if (r == 8) begin
        len = MaxLen + 1 + int'($urandom_range(3));
      end
      idle(int'($urandom_range(3)));
      mk_pkt(first, len);
      send_pkt(gap_pct);
      s = sync_e;
      e = eop_e;
      k = ap.size();
      // Packet k lands in bank k%2, which is free only once packet k-2 finished replaying.
      ok = (pkt[0] == 8'h0F) && (len >= 2) && (len <= MaxLen) &&
           ((k < 2) || (s > ap[k-2] + al[k-2] + 1));
      if (ok) begin
        p = (k == 0) ? e + 1 : imax(e + 1, ap[k-1] + al[k-1] + g);
        ap.push_back(p);
        al.push_back(len);
        for (int i = 0; i < len; i++) exp_d[p + 1 + i] = pkt[i];
        for (int c = p; c <= p + len + g - 2; c++) exp_b[c] = 1'b1;
      end else begin
`ifdef USB_RX_PACK_STAT_EN
        exp_drops++;
`endif
      end
    end
    idle(100);
    for (int c = start; c < ecnt - 1; c++) begin
      chk($sformatf("rand%0d rxd@%0d", hs, c - start), obs[c], exp_d[c]);
      chk($sformatf("rand%0d busy@%0d", hs, c - start), obs_b[c], exp_b[c]);
    end
`ifdef USB_RX_PACK_STAT_EN
    chk($sformatf("rand%0d drop_cnt", hs), drop_cnt, exp_drops);
`endif
  endtask

  typedef struct {
    logic [7:0] first;
    int         len;
    int         gap_pct;
    bit         play;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int re, e, e1, e2, pb, pc_s, pd_s;
    logic [7:0] p1[$];
    logic [7:0] p2[$];
    logic [7:0] pc[$];
    logic [7:0] pd[$];

    vecs[0] = '{8'h0F, 2,  50, 1'b1};
    vecs[1] = '{8'h55, 4,  30, 1'b0};
    vecs[2] = '{8'h0F, 1,  0,  1'b0};
    vecs[3] = '{8'h0F, 17, 0,  1'b0};
    vecs[4] = '{8'h0F, 16, 0,  1'b1};
    vecs[5] = '{8'h0F, 5,  30, 1'b1};
    vecs[6] = '{8'hF0, 1,  0,  1'b0};
    vecs[7] = '{8'h0F, 3,  0,  1'b1};

    rst_n = 1'b0;
    idle(2);
    do_reset(re);
    chk("reset rxd", obs[re], 8'h00);
    chk("reset busy", obs_b[re], 1'b0);
`ifdef USB_RX_PACK_STAT_EN
    chk("reset drop_cnt", drop_cnt, 16'h0000);
`endif

    // Directed single packets, fs/fd held high.
    rx_fs = 1'b1;
    rx_fd = 1'b1;
    for (int r = 0; r < 8; r++) begin
      mk_pkt(vecs[r].first, vecs[r].len);
      send_pkt(vecs[r].gap_pct);
      idle(vecs[r].len + 12);
      if (vecs[r].play) begin
        for (int i = 0; i < vecs[r].len; i++)
          chk($sformatf("vec%0d byte%0d", r, i), obs[eop_e + 2 + i], pkt[i]);
        chk($sformatf("vec%0d pre", r), obs[eop_e + 1], 8'h00);
        chk($sformatf("vec%0d post", r), obs[eop_e + 2 + vecs[r].len], 8'h00);
        chk($sformatf("vec%0d busy", r), obs_b[eop_e + 1], 1'b1);
        chk($sformatf("vec%0d idle", r), obs_b[eop_e + vecs[r].len + 5], 1'b0);
      end else begin
`ifdef USB_RX_PACK_STAT_EN
        exp_drops++;
`endif
        chk($sformatf("vec%0d silent", r), nonzero(sync_e, eop_e + vecs[r].len + 10), 0);
        chk($sformatf("vec%0d nobusy", r), obs_b[eop_e + 2], 1'b0);
      end
`ifdef USB_RX_PACK_STAT_EN
      chk($sformatf("vec%0d drop_cnt", r), drop_cnt, exp_drops);
`endif
    end

    // Handshake pacing: fs pulse after 12 cycles, fd held off past the timeout.
    rx_fs = 1'b0;
    rx_fd = 1'b0;
    idle(2);
    mk_pkt(8'h0F, 2);
    pkt[1] = 8'h2D;
    send_pkt(50);
    e = eop_e;
    while (ecnt + 1 < e + 12) tick();
    rx_fs = 1'b1;
    tick();
    rx_fs = 1'b0;
    while (ecnt + 1 < e + 25) tick();
    rx_fd = 1'b1;
    tick();
    rx_fd = 1'b0;
    idle(3);
    chk("hs sync", obs[e + 2], 8'h0F);
    chk("hs pid", obs[e + 3], 8'h2D);
    chk("hs zeros", nonzero(e + 4, e + 27), 0);
    chk("hs busy wfs", obs_b[e + 11], 1'b1);
    chk("hs busy wfd", obs_b[e + 24], 1'b1);
    chk("hs busy gap", obs_b[e + 25], 1'b1);
    chk("hs idle", obs_b[e + 26], 1'b0);

    // Three 8-byte packets at full rate with fs never asserted: third is dropped.
    mk_pkt(8'h0F, 8);
    p1 = pkt;
    send_pkt(0);
    e1 = eop_e;
    mk_pkt(8'h0F, 8);
    p2 = pkt;
    send_pkt(0);
    e2 = eop_e;
    mk_pkt(8'h0F, 8);
    send_pkt(0);
    idle(80);
    pb = imax(e2 + 1, e1 + 1 + 8 + GapTmo);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("b2b p1 byte%0d", i), obs[e1 + 2 + i], p1[i]);
      chk($sformatf("b2b p2 byte%0d", i), obs[pb + 1 + i], p2[i]);
    end
    chk("b2b gap zeros", nonzero(e1 + 10, pb), 0);
    chk("b2b p3 silent", nonzero(pb + 9, pb + 60), 0);
`ifdef USB_RX_PACK_STAT_EN
    exp_drops++;
    chk("b2b drop_cnt", drop_cnt, exp_drops);
`endif

    // Reset at byte 5 of a 10-byte replay while a second packet is pending.
    rx_fs = 1'b1;
    rx_fd = 1'b1;
    mk_pkt(8'h0F, 10);
    p1 = pkt;
    send_pkt(0);
    e = eop_e;
    mk_pkt(8'h0F, 4);
    send_pkt(0);
    while (ecnt + 1 < e + 6) tick();
    do_reset(re);
    for (int i = 0; i < 4; i++) chk($sformatf("rst byte%0d", i), obs[e + 2 + i], p1[i]);
    chk("rst rxd", obs[re], 8'h00);
    chk("rst busy", obs_b[re], 1'b0);
    idle(3);
    mk_pkt(8'h0F, 3);
    pc = pkt;
    send_pkt(0);
    e1 = eop_e;
    mk_pkt(8'h0F, 3);
    pd = pkt;
    send_pkt(0);
    e2 = eop_e;
    idle(30);
    pc_s = e1 + 1;
    pd_s = imax(e2 + 1, pc_s + 3 + GapHs);
    chk("rst quiet", nonzero(re, pc_s), 0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst C byte%0d", i), obs[pc_s + 1 + i], pc[i]);
      chk($sformatf("rst D byte%0d", i), obs[pd_s + 1 + i], pd[i]);
    end
`ifdef USB_RX_PACK_STAT_EN
    chk("rst drop_cnt", drop_cnt, 16'h0000);
`endif

    rand_phase(1'b1, 40);
    rand_phase(1'b0, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
